// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared types and helpers for the FIFO read-side packer
package fifo_rd_pkg;

    localparam int PACK_DEF = 4;
    localparam int MAX_PACK = 32;

    typedef logic [$clog2(PACK_DEF)-1:0] lane_t;

    // Contiguous lane mask with the low 'held' lanes set; callers truncate to PACK bits.
    function automatic logic [MAX_PACK-1:0] keep_mask(input int held);
        logic [MAX_PACK-1:0] m;
        for (int i = 0; i < MAX_PACK; i++) begin
            m[i] = (i < held);
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_rd_out_reg.sv
// rtl/fifo_rd_out_reg.sv - valid/ready holding register for packed words
module fifo_rd_out_reg #(
    parameter int DW = 32,
    parameter int KW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic [KW-1:0] load_keep,
    input  logic          load_last,
    input  logic          out_ready,
    output logic          out_free,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [KW-1:0] out_keep,
    output logic          out_last
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic [KW-1:0] keep_q, keep_d;
    logic          last_q, last_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        // load is only raised when the register is free, so it also covers the accept cycle
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            keep_d  = load_keep;
            last_d  = load_last;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end

    assign out_free  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_keep  = keep_q;
    assign out_last  = last_q;

endmodule

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - pops FIFO entries and packs them little-endian into wide words
module fifo_rd_packer
    import fifo_rd_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PACK      = PACK_DEF,
    parameter int CNT_W     = 16
) (
    input  logic                      rclk,
    input  logic                      rrst,
    input  logic                      rempty,
    input  logic [DATA_BITS-1:0]      rdata,
    output logic                      rinc,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_BITS*PACK-1:0] out_data,
    output logic [PACK-1:0]           out_keep,
    output logic                      out_last,
    output logic [CNT_W-1:0]          word_cnt
);

    localparam int DW = DATA_BITS * PACK;
    localparam int CW = $clog2(PACK);
    localparam int HW = $clog2(PACK + 1);

    logic [CW-1:0]    byte_cnt_q, byte_cnt_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic             flush_pend_q, flush_pend_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

    logic          out_free;
    logic          pop;
    logic          complete;
    logic          flush_eff;
    logic          emit;
    logic          load;
    logic [HW-1:0] held;
    logic [DW-1:0] merged;
    logic [PACK-1:0] keep_new;

    always_comb begin
        // The last lane is the only one that must wait for room in the output register.
        pop       = !rrst && !rempty && ((byte_cnt_q != CW'(PACK - 1)) || out_free);
        complete  = pop && (byte_cnt_q == CW'(PACK - 1));
        flush_eff = flush || flush_pend_q;
        held      = HW'(byte_cnt_q) + HW'(pop);
        emit      = flush_eff && !complete && (held != '0) && out_free;
        load      = complete || emit;
        keep_new  = PACK'(keep_mask(int'(held)));

        merged = acc_q;
        for (int i = 0; i < PACK; i++) begin
            if (pop && (byte_cnt_q == CW'(i))) begin
                merged[i*DATA_BITS +: DATA_BITS] = rdata;
            end
        end

        byte_cnt_d   = byte_cnt_q;
        acc_d        = acc_q;
        flush_pend_d = flush_pend_q;
        if (load) begin
            byte_cnt_d   = '0;
            acc_d        = '0;
            flush_pend_d = 1'b0;
        end else begin
            if (pop) begin
                acc_d      = merged;
                byte_cnt_d = byte_cnt_q + CW'(1);
            end
            // A flush that cannot emit yet is remembered; one with nothing to close is dropped.
            if (flush_eff) begin
                flush_pend_d = (held != '0);
            end
        end

        word_cnt_d = word_cnt_q + CNT_W'(out_valid && out_ready);
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            byte_cnt_q   <= '0;
            acc_q        <= '0;
            flush_pend_q <= 1'b0;
            word_cnt_q   <= '0;
        end else begin
            byte_cnt_q   <= byte_cnt_d;
            acc_q        <= acc_d;
            flush_pend_q <= flush_pend_d;
            word_cnt_q   <= word_cnt_d;
        end
    end

    fifo_rd_out_reg #(
        .DW (DW),
        .KW (PACK)
    ) u_out_reg (
        .clk       (rclk),
        .rst       (rrst),
        .load      (load),
        .load_data (merged),
        .load_keep (keep_new),
        .load_last (flush_eff),
        .out_ready (out_ready),
        .out_free  (out_free),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last)
    );

    assign rinc     = pop;
    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb/tb_fifo_rd_packer.sv - directed self-checking bench for fifo_rd_packer
module tb_fifo_rd_packer;

    logic        clk;
    logic        rrst;
    logic        rempty;
    logic [7:0]  rdata;
    logic        rinc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic [3:0]  word_cnt;

    int          checks;
    int          errors;
    logic [7:0]  fifo[$];
    logic [3:0]  exp_cnt;

    fifo_rd_packer #(
        .DATA_BITS (8),
        .PACK      (4),
        .CNT_W     (4)
    ) dut (
        .rclk      (clk),
        .rrst      (rrst),
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (rinc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .word_cnt  (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic refresh();
        rempty = (fifo.size() == 0);
        rdata  = rempty ? 8'h00 : fifo[0];
    endtask

    task automatic push(input logic [7:0] v);
        fifo.push_back(v);
        refresh();
    endtask

    // Samples rinc before the edge, retires the popped entry after it, returns at negedge.
    task automatic tick(output logic r);
        #1;
        r = rinc;
        @(posedge clk);
        #1;
        if (r && fifo.size() > 0) void'(fifo.pop_front());
        refresh();
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic r;
        rrst = 1'b1;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        for (int k = 0; k < 3; k++) begin
            tick(r);
            checks++;
            if (r !== 1'b0) begin errors++; $display("FAIL reset_rinc got %b exp 0", r); end
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
            checks++;
            if (word_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", word_cnt); end
        end
        checks++;
        if ({out_data, out_keep, out_last} !== 37'd0) begin
            errors++; $display("FAIL reset_out got %h/%h/%b exp 0", out_data, out_keep, out_last);
        end
        rrst = 1'b0;
        exp_cnt = 4'd0;
    endtask

    task automatic test_pack();
        logic r;
        int pops = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(r);
            pops += int'(r);
        end
        checks++;
        if (pops != 4) begin errors++; $display("FAIL pack_pops got %0d exp 4", pops); end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h44332211) begin
            errors++; $display("FAIL pack_data got %b/%h exp 1/44332211", out_valid, out_data);
        end
        checks++;
        if (out_keep !== 4'hF || out_last !== 1'b0) begin
            errors++; $display("FAIL pack_keep_last got %h/%b exp f/0", out_keep, out_last);
        end
        checks++;
        if (word_cnt !== 4'd0) begin errors++; $display("FAIL pack_cnt_pre got %0d exp 0", word_cnt); end
        tick(r);
        exp_cnt = 4'd1;
        checks++;
        if (r !== 1'b0) begin errors++; $display("FAIL pack_empty_rinc got %b exp 0", r); end
        checks++;
        if (word_cnt !== exp_cnt || out_valid !== 1'b0) begin
            errors++; $display("FAIL pack_accept got %0d/%b exp %0d/0", word_cnt, out_valid, exp_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic r;
        int pops = 0;
        out_ready = 1'b0;
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        for (int k = 0; k < 4; k++) tick(r);
        for (int k = 5; k <= 12; k++) push(8'(k));
        for (int k = 0; k < 6; k++) begin
            tick(r);
            pops += int'(r);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h04030201) begin
                errors++; $display("FAIL bp_hold got %b/%h exp 1/04030201", out_valid, out_data);
            end
        end
        checks++;
        if (pops != 3) begin errors++; $display("FAIL bp_pops got %0d exp 3", pops); end
        checks++;
        if (r !== 1'b0 || rempty !== 1'b0) begin
            errors++; $display("FAIL bp_stall got rinc %b rempty %b exp 0/0", r, rempty);
        end
        out_ready = 1'b1;
        tick(r);
        exp_cnt = exp_cnt + 4'd1;
        checks++;
        if (r !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'h08070605) begin
            errors++; $display("FAIL bp_b2b got %b/%b/%h exp 1/1/08070605", r, out_valid, out_data);
        end
        checks++;
        if (word_cnt !== exp_cnt) begin errors++; $display("FAIL bp_cnt got %0d exp %0d", word_cnt, exp_cnt); end
        for (int k = 0; k < 4; k++) tick(r);
        exp_cnt = exp_cnt + 4'd1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0C0B0A09 || word_cnt !== exp_cnt) begin
            errors++; $display("FAIL bp_next got %b/%h/%0d exp 1/0c0b0a09/%0d", out_valid, out_data, word_cnt, exp_cnt);
        end
        tick(r);
        exp_cnt = exp_cnt + 4'd1;
        checks++;
        if (out_valid !== 1'b0 || word_cnt !== exp_cnt) begin
            errors++; $display("FAIL bp_drain got %b/%0d exp 0/%0d", out_valid, word_cnt, exp_cnt);
        end
    endtask

    task automatic test_flush_partial();
        logic r;
        push(8'hAA); push(8'hBB);
        tick(r); tick(r);
        flush = 1'b1;
        tick(r);
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000BBAA) begin
            errors++; $display("FAIL fp_data got %b/%h exp 1/0000bbaa", out_valid, out_data);
        end
        checks++;
        if (out_keep !== 4'b0011 || out_last !== 1'b1) begin
            errors++; $display("FAIL fp_keep_last got %h/%b exp 3/1", out_keep, out_last);
        end
        tick(r);
        exp_cnt = exp_cnt + 4'd1;
        checks++;
        if (word_cnt !== exp_cnt) begin errors++; $display("FAIL fp_cnt got %0d exp %0d", word_cnt, exp_cnt); end
    endtask

    task automatic test_flush_full();
        logic r;
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
        tick(r); tick(r); tick(r);
        flush = 1'b1;
        tick(r);
        flush = 1'b0;
        checks++;
        if (out_data !== 32'hC4C3C2C1 || out_keep !== 4'hF || out_last !== 1'b1) begin
            errors++; $display("FAIL ff_word got %h/%h/%b exp c4c3c2c1/f/1", out_data, out_keep, out_last);
        end
        tick(r);
        exp_cnt = exp_cnt + 4'd1;
        flush = 1'b1;
        tick(r);
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL ff_empty_flush got %b exp 0", out_valid); end
        push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
        for (int k = 0; k < 4; k++) tick(r);
        checks++;
        if (out_data !== 32'hD4D3D2D1 || out_keep !== 4'hF || out_last !== 1'b0) begin
            errors++; $display("FAIL ff_no_pend got %h/%h/%b exp d4d3d2d1/f/0", out_data, out_keep, out_last);
        end
        tick(r);
        exp_cnt = exp_cnt + 4'd1;
        checks++;
        if (word_cnt !== exp_cnt) begin errors++; $display("FAIL ff_cnt got %0d exp %0d", word_cnt, exp_cnt); end
    endtask

    task automatic test_flush_pending();
        logic r;
        out_ready = 1'b0;
        push(8'hF1); push(8'hF2); push(8'hF3); push(8'hF4);
        for (int k = 0; k < 4; k++) tick(r);
        push(8'hE1);
        tick(r);
        flush = 1'b1;
        tick(r);
        flush = 1'b0;
        tick(r);
        push(8'hE2);
        tick(r);
        checks++;
        if (r !== 1'b1 || out_data !== 32'hF4F3F2F1 || out_last !== 1'b0) begin
            errors++; $display("FAIL pend_hold got %b/%h/%b exp 1/f4f3f2f1/0", r, out_data, out_last);
        end
        out_ready = 1'b1;
        tick(r);
        exp_cnt = exp_cnt + 4'd1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000E2E1 || out_keep !== 4'b0011 || out_last !== 1'b1) begin
            errors++; $display("FAIL pend_emit got %b/%h/%h/%b exp 1/0000e2e1/3/1", out_valid, out_data, out_keep, out_last);
        end
        checks++;
        if (word_cnt !== exp_cnt) begin errors++; $display("FAIL pend_cnt got %0d exp %0d", word_cnt, exp_cnt); end
        tick(r);
        exp_cnt = exp_cnt + 4'd1;
    endtask

    task automatic test_reset_midword_wrap();
        logic r;
        push(8'h01); push(8'h02);
        tick(r); tick(r);
        push(8'h99);
        rrst = 1'b1;
        tick(r);
        rrst = 1'b0;
        checks++;
        if (r !== 1'b0 || fifo.size() != 1) begin
            errors++; $display("FAIL mid_rst_pop got rinc %b depth %0d exp 0/1", r, fifo.size());
        end
        checks++;
        if (out_valid !== 1'b0 || word_cnt !== 4'd0) begin
            errors++; $display("FAIL mid_rst_out got %b/%0d exp 0/0", out_valid, word_cnt);
        end
        push(8'h98); push(8'h97); push(8'h96);
        for (int k = 0; k < 4; k++) tick(r);
        checks++;
        if (out_data !== 32'h96979899 || out_keep !== 4'hF) begin
            errors++; $display("FAIL mid_lane0 got %h/%h exp 96979899/f", out_data, out_keep);
        end
        tick(r);
        for (int w = 0; w < 16; w++) begin
            for (int b = 0; b < 4; b++) push(8'(w * 4 + b));
            for (int k = 0; k < 4; k++) tick(r);
        end
        checks++;
        if (out_data !== 32'h3F3E3D3C) begin
            errors++; $display("FAIL wrap_lastword got %h exp 3f3e3d3c", out_data);
        end
        tick(r);
        checks++;
        if (word_cnt !== 4'd1) begin errors++; $display("FAIL wrap_cnt got %0d exp 1", word_cnt); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rrst      = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        exp_cnt   = 4'd0;
        refresh();
        @(negedge clk);
        test_reset();
        test_pack();
        test_backpressure();
        test_flush_partial();
        test_flush_full();
        test_flush_pending();
        test_reset_midword_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
